// File: rtl/scan_bidir_routing_block.sv
// scan_bidir_routing_block
//   W-track, four-sided (left/right/top/bottom) bidirectional switch block. A serial scan
//   chain fills a shadow register. A load request validates the shadow. An accepted
//   configuration is committed only after every switch has been held open for GUARD cycles,
//   so a track never has two enabled sources at once.
// Ports
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   cfg_si, cfg_en        scan data in and shift enable (ignored while busy)
//   cfg_load              validate + commit request (ignored while busy)
//   cfg_so                scan data out, MSB of the shadow register
//   busy                  high while checking, guarding or committing
//   cfg_err               sticky: the most recent load was rejected
//   left/right/top/bottom W-bit bidirectional track pins, one bus per side
// Config bit map: cfg[12*t + 2*p + d]
//   p: 0 L-R, 1 L-T, 2 L-B, 3 R-T, 4 R-B, 5 T-B
//   d: 0 drives first->second, 1 drives second->first
module scan_bidir_routing_block #(
  parameter int unsigned W     = 3,
  parameter int unsigned GUARD = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_si,
  input  logic         cfg_en,
  input  logic         cfg_load,
  output logic         cfg_so,
  output logic         busy,
  output logic         cfg_err,
  inout  wire  [W-1:0] left,
  inout  wire  [W-1:0] right,
  inout  wire  [W-1:0] top,
  inout  wire  [W-1:0] bottom
);

  localparam int unsigned CFG_BITS = 12 * W;
  localparam int unsigned CntW     = $clog2(CFG_BITS + 2);
  localparam int unsigned GrdW     = $clog2(GUARD + 1);

  typedef enum logic [1:0] {StIdle, StCheck, StGuard, StCommit} state_e;

  state_e              state_q, state_d;
  logic [CFG_BITS-1:0] shadow_q, shadow_d;
  logic [CFG_BITS-1:0] active_q, active_d;
  logic [CntW-1:0]     count_q, count_d;
  logic [GrdW-1:0]     guard_q, guard_d;
  logic                err_q, err_d;

  logic                pair_bad, side_bad, cfg_ok;
  logic [CFG_BITS-1:0] sw;

  function automatic logic two_plus(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Validation of the shadow register.
  always_comb begin
    pair_bad = 1'b0;
    side_bad = 1'b0;
    for (int t = 0; t < int'(W); t++) begin
      for (int p = 0; p < 6; p++) begin
        pair_bad = pair_bad | (shadow_q[12*t+2*p] & shadow_q[12*t+2*p+1]);
      end
      // Drivers per side: L <- {R,T,B}, R <- {L,T,B}, T <- {L,R,B}, B <- {L,R,T}
      side_bad = side_bad
               | two_plus(shadow_q[12*t+1], shadow_q[12*t+3], shadow_q[12*t+5])
               | two_plus(shadow_q[12*t+0], shadow_q[12*t+7], shadow_q[12*t+9])
               | two_plus(shadow_q[12*t+2], shadow_q[12*t+6], shadow_q[12*t+11])
               | two_plus(shadow_q[12*t+4], shadow_q[12*t+8], shadow_q[12*t+10]);
    end
    cfg_ok = (count_q == CntW'(CFG_BITS)) && !pair_bad && !side_bad;
  end

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    active_d = active_q;
    count_d  = count_q;
    guard_d  = guard_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (cfg_load) begin
          state_d = StCheck;
          err_d   = 1'b0;
        end else if (cfg_en) begin
          shadow_d = {shadow_q[CFG_BITS-2:0], cfg_si};
          if (count_q != CntW'(CFG_BITS + 1)) begin
            count_d = count_q + 1'b1;
          end
        end
      end
      StCheck: begin
        if (cfg_ok) begin
          state_d = StGuard;
          guard_d = '0;
        end else begin
          state_d = StIdle;
          err_d   = 1'b1;
          count_d = '0;
        end
      end
      StGuard: begin
        if (guard_q == GrdW'(GUARD - 1)) begin
          state_d = StCommit;
        end else begin
          guard_d = guard_q + 1'b1;
        end
      end
      StCommit: begin
        active_d = shadow_q;
        count_d  = '0;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      shadow_q <= '0;
      active_q <= '0;
      count_q  <= '0;
      guard_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      count_q  <= count_d;
      guard_q  <= guard_d;
      err_q    <= err_d;
    end
  end

  assign cfg_so  = shadow_q[CFG_BITS-1];
  assign busy    = (state_q != StIdle);
  assign cfg_err = err_q;

  // Break-before-make: the active config is masked (not cleared) while guarding/committing.
  assign sw = ((state_q == StGuard) || (state_q == StCommit)) ? '0 : active_q;

  for (genvar t = 0; t < int'(W); t++) begin : g_track
    logic [11:0] s;
    assign s = sw[12*t +: 12];

    assign left[t]   = (s[1] | s[3] | s[5])
                     ? ((s[1] & right[t]) | (s[3] & top[t]) | (s[5] & bottom[t])) : 1'bz;
    assign right[t]  = (s[0] | s[7] | s[9])
                     ? ((s[0] & left[t]) | (s[7] & top[t]) | (s[9] & bottom[t])) : 1'bz;
    assign top[t]    = (s[2] | s[6] | s[11])
                     ? ((s[2] & left[t]) | (s[6] & right[t]) | (s[11] & bottom[t])) : 1'bz;
    assign bottom[t] = (s[4] | s[8] | s[10])
                     ? ((s[4] & left[t]) | (s[8] & right[t]) | (s[10] & top[t])) : 1'bz;
  end

endmodule
